// File: rtl/ap_multi_controller.sv
// Per-channel ap_ctrl_hs launcher: start queue, credit-limited ap_start, in-flight and finished counters.
// Optional watchdog on ap_start-without-ap_ready enabled by defining AP_CTRL_TIMEOUT_EN.
module ap_multi_controller #(
  parameter int NUM_CH  = 4,
  parameter int PEND_W  = 4,
  parameter int FIN_W   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic [NUM_CH-1:0]        start_trig,
  input  logic [NUM_CH-1:0]        complete_trig,
  output logic [NUM_CH-1:0]        finish,
  output logic [NUM_CH*FIN_W-1:0]  fin_cnt,
  output logic [NUM_CH*PEND_W-1:0] pend_cnt,
  output logic [NUM_CH-1:0]        start_drop,
  output logic [NUM_CH-1:0]        idle,
  output logic                     all_idle,
  output logic [NUM_CH-1:0]        proto_err,
  output logic [NUM_CH-1:0]        timeout_err,
  output logic [NUM_CH-1:0]        ap_start,
  input  logic [NUM_CH-1:0]        ap_ready,
  input  logic [NUM_CH-1:0]        ap_done,
  input  logic [NUM_CH-1:0]        ap_idle
);

  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
  localparam logic [FIN_W:0]    FIN_MAX  = {1'b0, {FIN_W{1'b1}}};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [PEND_W-1:0] pend_q, pend_d;
    logic [FIN_W-1:0]  infl_q, infl_d;
    logic [FIN_W-1:0]  fin_q, fin_d;
    logic              start_q, start_d;
    logic              drop_q, drop_d;
    logic              perr_q, perr_d;
    logic              launch_s, accept_s, done_ok_s, claim_s;
    logic [FIN_W:0]    credit_sum_s;

    // Counter next-state: credit is checked on next-state values so ap_start only falls after a launch
    always_comb begin
      launch_s     = start_q & ap_ready[g];
      accept_s     = start_trig[g] & ((pend_q != PEND_MAX) | launch_s);
      done_ok_s    = ap_done[g] & (infl_q != {FIN_W{1'b0}});
      claim_s      = complete_trig[g] & (fin_q != {FIN_W{1'b0}});
      pend_d       = pend_q + PEND_W'(accept_s) - PEND_W'(launch_s);
      infl_d       = infl_q + FIN_W'(launch_s) - FIN_W'(done_ok_s);
      fin_d        = fin_q + FIN_W'(done_ok_s) - FIN_W'(claim_s);
      credit_sum_s = {1'b0, fin_d} + {1'b0, infl_d};
      start_d      = (pend_d != {PEND_W{1'b0}}) & (credit_sum_s < FIN_MAX);
      drop_d       = start_trig[g] & ~accept_s;
      perr_d       = perr_q | (ap_done[g] & (infl_q == {FIN_W{1'b0}}));
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
        pend_q  <= {PEND_W{1'b0}};
        infl_q  <= {FIN_W{1'b0}};
        fin_q   <= {FIN_W{1'b0}};
        start_q <= 1'b0;
        drop_q  <= 1'b0;
        perr_q  <= 1'b0;
      end else begin
        pend_q  <= pend_d;
        infl_q  <= infl_d;
        fin_q   <= fin_d;
        start_q <= start_d;
        drop_q  <= drop_d;
        perr_q  <= perr_d;
      end
    end

    assign fin_cnt[g*FIN_W +: FIN_W]    = fin_q;
    assign pend_cnt[g*PEND_W +: PEND_W] = pend_q;
    assign finish[g]     = (fin_q != {FIN_W{1'b0}});
    assign start_drop[g] = drop_q;
    assign proto_err[g]  = perr_q;
    assign ap_start[g]   = start_q;
    assign idle[g]       = ap_idle[g] & (pend_q == {PEND_W{1'b0}}) & (infl_q == {FIN_W{1'b0}})
                         & (fin_q == {FIN_W{1'b0}}) & ~start_q;

`ifdef AP_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          terr_q, terr_d;

    // Watchdog counts stalled ap_start cycles, saturating at the limit
    always_comb begin
      tcnt_d = {TW{1'b0}};
      if (start_q & ~ap_ready[g]) begin
        if (tcnt_q == TW'(TIMEOUT)) begin
          tcnt_d = tcnt_q;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end else begin
        tcnt_d = {TW{1'b0}};
      end
      terr_d = terr_q | (tcnt_d == TW'(TIMEOUT));
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
        tcnt_q <= {TW{1'b0}};
        terr_q <= 1'b0;
      end else begin
        tcnt_q <= tcnt_d;
        terr_q <= terr_d;
      end
    end

    assign timeout_err[g] = terr_q;
`else
    assign timeout_err[g] = 1'b0;
`endif
  end

  assign all_idle = &idle;

endmodule

// File: doc/ap_multi_controller.md
# ap_multi_controller

Multi-channel HLS block-level handshake controller for NUM_CH independent ap_ctrl_hs kernels. Per channel it queues start requests and drives ap_start under the HLS "hold until ap_ready" rule. It tracks tasks launched but not yet done, and counts finished tasks until software claims them. Launches are credit-limited so the finished count can never overflow. It sits between the host register/command layer and the HLS kernel instances.

## Interface
- NUM_CH, 4, number of kernel channels (1..16)
- PEND_W, 4, width of per-channel pending-start counter; max pending = 2^PEND_W-1
- FIN_W, 4, width of in-flight and finished counters; FIN_MAX = 2^FIN_W-1
- TIMEOUT, 1024, watchdog limit in cycles (used only with AP_CTRL_TIMEOUT_EN)

- ap_clk  in  1  clock
- ap_rst  in  1  asynchronous, active-high reset
- start_trig  in  NUM_CH  per-channel request to queue one task
- complete_trig  in  NUM_CH  per-channel claim of one finished task
- finish  out  NUM_CH  fin_cnt[i] != 0
- fin_cnt  out  NUM_CH*FIN_W  finished-unclaimed count, channel i at [i*FIN_W +: FIN_W]
- pend_cnt  out  NUM_CH*PEND_W  queued-not-launched count
- start_drop  out  NUM_CH  1-cycle pulse: start_trig rejected (queue full)
- idle  out  NUM_CH  channel fully quiescent
- all_idle  out  1  AND of idle
- proto_err  out  NUM_CH  sticky: ap_done seen with zero in-flight
- timeout_err  out  NUM_CH  sticky watchdog flag (0 when macro off)
- ap_start  out  NUM_CH  to kernel, registered
- ap_ready, ap_done, ap_idle  in  NUM_CH each  from kernel

## Operation
- Per channel, three counters: pend (PEND_W), infl (FIN_W), fin (FIN_W).
- launch = ap_start & ap_ready. accept = start_trig & (pend != max | launch).
- pend_next = pend + accept - launch.
- infl_next = infl + launch - (ap_done & infl != 0).
- fin_next = fin + (ap_done & infl != 0) - (complete_trig & fin != 0).
- complete_trig with fin == 0 is ignored. ap_done with infl == 0 is ignored and sets proto_err.
- ap_start register <= (pend_next != 0) & (fin_next + infl_next < FIN_MAX). Compare is FIN_W+1 bits wide.
- Credit only falls on launch, so ap_start never drops before ap_ready. It stays high back-to-back while both pend and credit remain.
- start_drop <= start_trig & ~accept (registered).
- idle = ap_idle & (pend == 0) & (infl == 0) & (fin == 0) & ~ap_start (combinational).
- Channels are fully independent; there is no arbitration.
- Simultaneous events: trig+launch at full queue is accepted. ap_done+complete_trig nets fin unchanged (when fin != 0). Launch+done in the same cycle nets infl unchanged.

## Timing
- start_trig at cycle n on an empty, credited channel -> ap_start high at n+1.
- ap_ready sampled at edge m with pend_next == 0 -> ap_start low at m+1.
- ap_done at n -> fin/finish updated at n+1.
- Reset: asynchronous. ap_start, all counters, start_drop, proto_err and timeout_err go to 0 immediately. idle then equals ap_idle.
- Reset mid-task drops ap_start at once. Kernel-side recovery is the system's responsibility.

## Configuration
- AP_CTRL_TIMEOUT_EN defined: per-channel counter (clog2(TIMEOUT+1) bits) increments each cycle ap_start & ~ap_ready, clears on ap_ready or ~ap_start. On reaching TIMEOUT it sets timeout_err[i] (sticky until reset). It does not alter ap_start.
- Not defined: no counter logic; timeout_err tied to 0.

## Test plan
- Ch0: one start_trig; ap_ready at cycle 3, ap_done at 6 -> ap_start high cycles 1-3; fin_cnt=1 at 7; complete_trig -> fin_cnt=0, idle=1.
- Ch1, PEND_W=2: 5 start_trig pulses with ap_ready held 0 -> pend_cnt=3; start_drop pulses on the 4th and 5th; then ready -> 3 back-to-back launches.
- Ch2, FIN_W=2: 4 queued tasks, ap_ready=1, ap_done immediately, never claimed -> exactly 3 launches; ap_start stays 0 with pend=1 until one complete_trig, then relaunches.
- Ch3: ap_done with infl=0 -> proto_err=1, fin_cnt unchanged. Simultaneous done+complete_trig with fin=2 -> fin stays 2.
- Assert ap_rst mid-launch with ap_start=1, pend=2 -> ap_start=0 same cycle, all counts 0.
- AP_CTRL_TIMEOUT_EN, TIMEOUT=8: ap_start held with no ap_ready -> timeout_err set after 8 cycles. Macro off -> stays 0.
